// File: rtl/para.sv
// rtl/para.sv - shared widths and FSM state type for the fetch controller
package para;

  localparam int REG_W  = 5;
  localparam int XLEN   = 32;
  localparam int FCNT_W = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between ID sources and EX load
module hazard_detect
  import para::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             hazard
);

  // x0 is never a real producer, so a load targeting it cannot cause a hazard
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch redirect/stall/halt controller with saturating event counters
module fetch_ctrl
  import para::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             stall,
  output logic             dnpc_flag,
  output logic [XLEN-1:0]  dnpc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);

  fetch_ctrl_state_t state, state_n;
  logic [FCNT_W-1:0] fcnt_q, fcnt_n;
  logic              hazard;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      fcnt_q <= '0;
    end else begin
      state  <= state_n;
      fcnt_q <= fcnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    fcnt_n     = fcnt_q;
    stall      = 1'b0;
    dnpc_flag  = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        if (ex_redirect) begin
          dnpc_flag  = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state_n = FLUSH;
            fcnt_n  = FLUSH_LOAD;
          end
        end else begin
          if (hazard) begin
            stall      = 1'b1;
            flush_idex = 1'b1;
          end
          if (halt_req) state_n = HALT;
        end
      end
      FLUSH: begin
        flush_ifid = 1'b1;
        if (ex_redirect) begin
          dnpc_flag  = 1'b1;
          flush_idex = 1'b1;
          fcnt_n     = FLUSH_LOAD;
        end else if (fcnt_q <= 2'd1) begin
          state_n = RUN;
          fcnt_n  = '0;
        end else begin
          fcnt_n = fcnt_q - 2'd1;
        end
      end
      HALT: begin
        stall      = 1'b1;
        flush_idex = 1'b1;
        halted     = 1'b1;
        // a held halt request outranks resume
        if (resume_req && !halt_req) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign dnpc = dnpc_flag ? ex_target : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

  localparam int FC   = 1;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b1;
  logic          reset = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0, ex_redirect = 0;
  logic [31:0]   ex_target = '0;
  logic          halt_req = 0, resume_req = 0;
  logic          stall, dnpc_flag, flush_ifid, flush_idex, halted;
  logic [31:0]   dnpc;
  logic [CW-1:0] stall_cnt, flush_cnt;

  fetch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .halt_req    (halt_req),
    .resume_req  (resume_req),
    .stall       (stall),
    .dnpc_flag   (dnpc_flag),
    .dnpc        (dnpc),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          stall, dflag, ifid, idex, halted;
    logic [31:0]   dnpc;
    logic [CW-1:0] scnt, fcnt;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // reference model: parked core, remaining flush cycles, plain integer counters
  bit   m_parked = 0;
  int   m_flush_left = 0;
  int   m_scnt = 0;
  int   m_fcnt = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, c, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",      e.cyc, {31'b0, stall},      {31'b0, e.stall});
      chk("dnpc_flag",  e.cyc, {31'b0, dnpc_flag},  {31'b0, e.dflag});
      chk("dnpc",       e.cyc, dnpc,                e.dnpc);
      chk("flush_ifid", e.cyc, {31'b0, flush_ifid}, {31'b0, e.ifid});
      chk("flush_idex", e.cyc, {31'b0, flush_idex}, {31'b0, e.idex});
      chk("halted",     e.cyc, {31'b0, halted},     {31'b0, e.halted});
      chk("stall_cnt",  e.cyc, {28'b0, stall_cnt},  {28'b0, e.scnt});
      chk("flush_cnt",  e.cyc, {28'b0, flush_cnt},  {28'b0, e.fcnt});
    end
  end

  task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rd, input bit mr,
                      input bit redir, input logic [31:0] tgt, input bit hreq, input bit rreq);
    exp_t e;
    bit   hz;
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; ex_target = tgt;
    halt_req = hreq; resume_req = rreq;
    if (!rst) begin
      m_parked = 0; m_flush_left = 0; m_scnt = 0; m_fcnt = 0;
    end
    hz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.stall = 0; e.dflag = 0; e.ifid = 0; e.idex = 0; e.halted = 0; e.dnpc = '0;
    if (m_parked) begin
      e.stall = 1; e.idex = 1; e.halted = 1;
    end else if (redir) begin
      e.dflag = 1; e.dnpc = tgt; e.ifid = 1; e.idex = 1;
    end else if (m_flush_left > 0) begin
      e.ifid = 1;
    end else if (hz) begin
      e.stall = 1; e.idex = 1;
    end
    e.scnt = CW'(m_scnt);
    e.fcnt = CW'(m_fcnt);
    e.cyc  = cyc;
    q.push_back(e);
    @(posedge clock);
    if (rst) begin
      if (e.stall && m_scnt < MAXC) m_scnt++;
      if (e.ifid && m_fcnt < MAXC) m_fcnt++;
      if (m_parked) begin
        if (rreq && !hreq) m_parked = 0;
      end else if (redir) m_flush_left = FC;
      else if (m_flush_left > 0) m_flush_left--;
      else if (hreq) m_parked = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit hreq = 0, input bit rreq = 0);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, hreq, rreq);
  endtask

  initial begin
    int wait_cyc;
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load x5 then consumer of x5
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    idle(2);
    // load to x0 never stalls
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100, 0, 0);
    idle(3);
    // redirect beats hazard
    step(1, 7, 7, 0, 1, 7, 1, 1, 32'hDEAD_BEE0, 0, 0);
    idle(2);
    // halt raised during flush
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_2000, 0, 0);
    idle(4, 1, 0);
    idle(1, 0, 1);
    idle(2);
    // halt and resume together keeps the core parked
    idle(1, 1, 0);
    idle(2, 1, 1);
    idle(1, 0, 1);
    idle(1);
    // long halt drives stall_cnt into saturation, then async reset
    idle(20, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end
    idle(2);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clock);
      wait_cyc++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning the number of extra IF/ID flush cycles after a redirect (range 0..3).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-003 SHALL have the port clock  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port reset  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have the port id_rs1, id_rs2  in  5 each  meaning the ID-stage source registers.
REQ-006 SHALL have the port id_rs1_used, id_rs2_used  in  1 each  meaning the ID instruction reads that source.
REQ-007 SHALL have the port ex_rd  in  5  meaning the EX-stage destination register.
REQ-008 SHALL have the port ex_mem_read  in  1  meaning the EX instruction is a load.
REQ-009 SHALL have the port ex_redirect  in  1  meaning a taken branch or jump resolved in EX.
REQ-010 SHALL have the port ex_target  in  32  meaning the redirect target.
REQ-011 SHALL have the port halt_req, resume_req  in  1 each  meaning level requests from the debug/trace harness.
REQ-012 SHALL have the port stall  out  1  meaning hold the fetch PC and the IF/ID register.
REQ-013 SHALL have the port dnpc_flag  out  1  meaning load dnpc into the fetch PC.
REQ-014 SHALL have the port dnpc  out  32  meaning the next-PC value.
REQ-015 SHALL have the port flush_ifid, flush_idex  out  1 each  meaning insert a bubble into that pipeline register.
REQ-016 SHALL have the port halted  out  1  meaning the core is parked.
REQ-017 SHALL have the port stall_cnt, flush_cnt  out  CNT_W each  meaning saturating event counters.

Function
REQ-018 SHALL implement the FSM states RUN, FLUSH, HALT.
REQ-019 SHALL define load-use hazard = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-020 In RUN with ex_redirect=1, SHALL assert dnpc_flag=1, dnpc=ex_target, flush_ifid=1 and flush_idex=1 in the same cycle (combinational), then go to FLUSH if FLUSH_CYCLES>0, else stay in RUN.
REQ-021 In FLUSH, SHALL assert flush_ifid=1, keep stall=0 and dnpc_flag=0, and return to RUN after FLUSH_CYCLES cycles via a 2-bit down-counter.
REQ-022 In RUN with a hazard and no redirect, SHALL assert stall=1 and flush_idex=1 for exactly that cycle, with no state change.
REQ-023 Redirect SHALL take priority over hazard; when both occur, stall=0.
REQ-024 A new ex_redirect during FLUSH SHALL be honoured as in REQ-020 and reload the counter.
REQ-025 halt_req=1 SHALL move the FSM to HALT only from RUN with no redirect pending; a request raised during FLUSH is deferred until RUN.
REQ-026 In HALT, SHALL assert stall=1, flush_idex=1 and halted=1, and ignore hazard and ex_redirect.
REQ-027 In HALT with resume_req=1, SHALL go to RUN on the next edge; resume_req outside HALT has no effect.
REQ-028 When halt_req and resume_req are both high in HALT, halt SHALL win and the FSM stays in HALT.
REQ-029 dnpc SHALL equal ex_target whenever dnpc_flag=1 and SHALL be 0 otherwise.
REQ-030 stall_cnt SHALL increment on every cycle with stall=1; flush_cnt SHALL increment on every cycle with flush_ifid=1; both saturate at all-ones with no wrap.

Reset
REQ-031 While reset=0, SHALL asynchronously set state=RUN, the flush counter to 0 and both perf counters to 0.
REQ-032 With reset=0 (state RUN), outputs SHALL follow REQ-019..REQ-029 combinationally from the inputs; all outputs SHALL be 0 when all inputs are 0.
REQ-033 A reset asserted mid-FLUSH or in HALT SHALL abort immediately; the first cycle after release SHALL be in RUN.

Structure
REQ-034 The state enum fetch_ctrl_state_t and the width constants SHALL be placed in the shared package para.sv.
REQ-035 The hazard compare SHALL be a separate combinational sub-module hazard_detect; the FSM and counters stay in fetch_ctrl.

Verification
REQ-036 Load x5, then ID reads rs1=x5 -> exactly 1 cycle with stall=1 and flush_idex=1; stall_cnt=1.
REQ-037 ex_mem_read=1 with ex_rd=0 matching rs1=0 -> no stall.
REQ-038 ex_redirect with ex_target=0x0000_0100 -> same cycle dnpc_flag=1 and dnpc=0x100; then flush_ifid=1 for 1 more cycle (FLUSH_CYCLES=1); flush_cnt=2.
REQ-039 Hazard and redirect in the same cycle -> stall=0 and dnpc_flag=1.
REQ-040 halt_req during FLUSH -> HALT entered only after FLUSH ends; halted=1; resume_req -> RUN next cycle.
REQ-041 reset=0 pulse mid-HALT, and stall_cnt forced near saturation (CNT_W=4, 20 stall cycles) -> asynchronous return to RUN; counter holds at 4'hF.
